// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer for the EOS S3 fabric LEDs: accepts mode/period commands and
// steps an off/blink/chase/count pattern on a prescaled tick.
module led_pattern_ctrl #(
    parameter int TICK_DIV   = 50000,
    parameter int PRESCALE_W = 16
) (
    input  logic       WB_CLK,
    input  logic       WB_RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [7:0] cmd_period,
    output logic [2:0] led,
    output logic       step_tick,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_BLINK = 2'd1;
    localparam logic [1:0] MODE_CHASE = 2'd2;
    localparam logic [1:0] MODE_COUNT = 2'd3;

    localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(TICK_DIV - 1);

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [7:0]            step_q, step_d;
    logic [1:0]            mode_q, mode_d;
    logic [7:0]            period_q, period_d;
    logic [2:0]            led_q, led_d;
    logic                  step_tick_q, step_tick_d;

    logic accept;
    logic tick;

    assign cmd_ready = (state_q != APPLY);
    assign running   = (state_q == RUN);
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = running && (presc_q == PRESC_MAX);

    assign led       = led_q;
    assign step_tick = step_tick_q;

    function automatic logic [2:0] advance(input logic [1:0] mode, input logic [2:0] cur);
        case (mode)
            MODE_BLINK: advance = ~cur;
            MODE_CHASE: advance = {cur[1:0], cur[2]};
            MODE_COUNT: advance = cur + 3'd1;
            default:    advance = cur;
        endcase
    endfunction

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            step_q      <= '0;
            mode_q      <= MODE_OFF;
            period_q    <= 8'd1;
            led_q       <= 3'b000;
            step_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            step_q      <= step_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            led_q       <= led_d;
            step_tick_q <= step_tick_d;
        end
    end

    // A command accepted in RUN preempts any advance due on the same edge.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        step_d      = step_q;
        mode_d      = mode_q;
        period_d    = period_q;
        led_d       = led_q;
        step_tick_d = 1'b0;

        if (accept) begin
            mode_d   = cmd_mode;
            period_d = (cmd_period == 8'd0) ? 8'd1 : cmd_period;
        end

        case (state_q)
            IDLE: begin
                presc_d = '0;
                step_d  = '0;
                if (accept) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                presc_d = '0;
                step_d  = '0;
                case (mode_q)
                    MODE_BLINK: led_d = 3'b111;
                    MODE_CHASE: led_d = 3'b001;
                    default:    led_d = 3'b000;
                endcase
                state_d = (mode_q == MODE_OFF) ? IDLE : RUN;
            end
            RUN: begin
                if (accept) begin
                    presc_d = '0;
                    step_d  = '0;
                    state_d = APPLY;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (step_q == period_q - 8'd1) begin
                            step_d      = '0;
                            led_d       = advance(mode_q, led_q);
                            step_tick_d = 1'b1;
                        end else begin
                            step_d = step_q + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with a short prescaler (TICK_DIV=4) and
// hand-computed LED sequences.
module tb_led_pattern_ctrl;

    localparam int TICK_DIV = 4;

    logic       WB_CLK;
    logic       WB_RST;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_period;
    logic [2:0] led;
    logic       step_tick;
    logic       running;

    int checks;
    int failures;

    led_pattern_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .PRESCALE_W(4)
    ) dut (
        .WB_CLK    (WB_CLK),
        .WB_RST    (WB_RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_period(cmd_period),
        .led       (led),
        .step_tick (step_tick),
        .running   (running)
    );

    initial WB_CLK = 1'b0;
    always #5 WB_CLK = ~WB_CLK;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance n clock edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge WB_CLK);
        #1;
    endtask

    // Present a command and return just after its accepting edge (E0).
    task automatic applyStimulus(input logic [1:0] mode, input logic [7:0] period);
        int waited;
        cmd_valid  = 1'b1;
        cmd_mode   = mode;
        cmd_period = period;
        waited     = 0;
        while (!cmd_ready && waited < 20) begin
            step(1);
            waited++;
        end
        if (!cmd_ready) checkOutput("cmd_ready_timeout", {7'd0, cmd_ready}, 8'd1);
        step(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        WB_RST     = 1'b1;
        cmd_valid  = 1'b1;
        cmd_mode   = 2'd2;
        cmd_period = 8'd2;

        // Reset held for two edges with a command pending.
        step(2);
        checkOutput("rst_led", {5'd0, led}, 8'd0);
        checkOutput("rst_ready", {7'd0, cmd_ready}, 8'd1);
        checkOutput("rst_running", {7'd0, running}, 8'd0);
        checkOutput("rst_step_tick", {7'd0, step_tick}, 8'd0);
        WB_RST    = 1'b0;
        cmd_valid = 1'b0;
        step(1);
        checkOutput("post_rst_running", {7'd0, running}, 8'd0);
        checkOutput("post_rst_ready", {7'd0, cmd_ready}, 8'd1);

        // CHASE, period 2: advances at E9, E17, E25.
        applyStimulus(2'd2, 8'd2);
        checkOutput("chase_apply_ready", {7'd0, cmd_ready}, 8'd0);
        checkOutput("chase_apply_running", {7'd0, running}, 8'd0);
        step(1);
        checkOutput("chase_e1_led", {5'd0, led}, 8'd1);
        checkOutput("chase_e1_running", {7'd0, running}, 8'd1);
        checkOutput("chase_e1_ready", {7'd0, cmd_ready}, 8'd1);
        checkOutput("chase_e1_step_tick", {7'd0, step_tick}, 8'd0);
        step(7);
        checkOutput("chase_e8_led", {5'd0, led}, 8'd1);
        step(1);
        checkOutput("chase_e9_led", {5'd0, led}, 8'd2);
        checkOutput("chase_e9_step_tick", {7'd0, step_tick}, 8'd1);
        step(1);
        checkOutput("chase_e10_step_tick", {7'd0, step_tick}, 8'd0);
        step(7);
        checkOutput("chase_e17_led", {5'd0, led}, 8'd4);
        checkOutput("chase_e17_step_tick", {7'd0, step_tick}, 8'd1);
        step(8);
        checkOutput("chase_e25_led", {5'd0, led}, 8'd1);
        checkOutput("chase_e25_step_tick", {7'd0, step_tick}, 8'd1);

        // COUNT accepted on E33, the edge of the next pending CHASE advance.
        step(7);
        applyStimulus(2'd3, 8'd1);
        checkOutput("preempt_led", {5'd0, led}, 8'd1);
        checkOutput("preempt_step_tick", {7'd0, step_tick}, 8'd0);
        checkOutput("preempt_ready", {7'd0, cmd_ready}, 8'd0);
        step(1);
        checkOutput("preempt_e1_led", {5'd0, led}, 8'd0);
        checkOutput("preempt_e1_running", {7'd0, running}, 8'd1);

        // COUNT, period 1: one increment every TICK_DIV cycles, wrapping 7 -> 0.
        for (int k = 1; k <= 8; k++) begin
            step(TICK_DIV);
            checkOutput($sformatf("count_led_%0d", k), {5'd0, led}, 8'(k % 8));
            checkOutput($sformatf("count_tick_%0d", k), {7'd0, step_tick}, 8'd1);
        end

        // Reset mid-RUN with led = 101, then restart from a fresh E1.
        step(5 * TICK_DIV);
        checkOutput("midrun_led", {5'd0, led}, 8'd5);
        WB_RST = 1'b1;
        step(1);
        WB_RST = 1'b0;
        checkOutput("midrst_led", {5'd0, led}, 8'd0);
        checkOutput("midrst_running", {7'd0, running}, 8'd0);
        checkOutput("midrst_ready", {7'd0, cmd_ready}, 8'd1);
        checkOutput("midrst_step_tick", {7'd0, step_tick}, 8'd0);
        step(10);
        checkOutput("midrst_idle_led", {5'd0, led}, 8'd0);
        applyStimulus(2'd3, 8'd1);
        step(1);
        checkOutput("restart_e1_led", {5'd0, led}, 8'd0);
        step(TICK_DIV - 1);
        checkOutput("restart_pre_led", {5'd0, led}, 8'd0);
        step(1);
        checkOutput("restart_adv_led", {5'd0, led}, 8'd1);

        // BLINK with period 0 behaves as period 1.
        applyStimulus(2'd1, 8'd0);
        step(1);
        checkOutput("blink0_e1_led", {5'd0, led}, 8'd7);
        step(TICK_DIV - 1);
        checkOutput("blink0_pre_led", {5'd0, led}, 8'd7);
        step(1);
        checkOutput("blink0_adv_led", {5'd0, led}, 8'd0);
        checkOutput("blink0_adv_tick", {7'd0, step_tick}, 8'd1);
        step(TICK_DIV);
        checkOutput("blink0_adv2_led", {5'd0, led}, 8'd7);

        // BLINK with period 255: first toggle exactly 255*TICK_DIV cycles after E1.
        applyStimulus(2'd1, 8'd255);
        step(1);
        checkOutput("blink255_e1_led", {5'd0, led}, 8'd7);
        step(255 * TICK_DIV - 1);
        checkOutput("blink255_pre_led", {5'd0, led}, 8'd7);
        checkOutput("blink255_pre_tick", {7'd0, step_tick}, 8'd0);
        step(1);
        checkOutput("blink255_adv_led", {5'd0, led}, 8'd0);
        checkOutput("blink255_adv_tick", {7'd0, step_tick}, 8'd1);

        // OFF returns to IDLE and holds the LEDs dark.
        applyStimulus(2'd0, 8'd5);
        step(1);
        checkOutput("off_led", {5'd0, led}, 8'd0);
        checkOutput("off_running", {7'd0, running}, 8'd0);
        checkOutput("off_ready", {7'd0, cmd_ready}, 8'd1);
        step(10 * TICK_DIV);
        checkOutput("off_hold_led", {5'd0, led}, 8'd0);
        checkOutput("off_hold_tick", {7'd0, step_tick}, 8'd0);
        checkOutput("off_hold_running", {7'd0, running}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Controller that sequences the three-LED output of the FPGA fabric on the EOS S3 board. A command port selects a display mode (off, blink, chase, binary count) and a step period. A prescaler plus step counter time the pattern advances. The block is clocked from the gclkbuff-buffered fabric clock and replaces a free-running counter driving `led[2:0]`.

## Interface
- `TICK_DIV`, default 50000: fabric clock cycles per prescaler tick (≥2).
- `PRESCALE_W`, default 16: prescaler width; must satisfy 2^PRESCALE_W ≥ TICK_DIV.
- `WB_CLK`, in, 1: fabric clock (the only clock). All logic on posedge.
- `WB_RST`, in, 1: reset, synchronous, active-high.
- `cmd_valid`, in, 1: command present. Source holds the command stable until accepted.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_mode`, in, 2: 0 = OFF, 1 = BLINK, 2 = CHASE, 3 = COUNT.
- `cmd_period`, in, 8: ticks per pattern step. 0 is treated as 1.
- `led`, out, 3: registered LED drive.
- `step_tick`, out, 1: registered one-cycle pulse, high in the first cycle `led` shows an advanced pattern.
- `running`, out, 1: high while in RUN.

## Operation
- **Reset values** (edge with `WB_RST`=1):
  - state IDLE; `led` = 000, `cmd_ready` = 1, `step_tick` = 0, `running` = 0.
  - prescaler = 0, step counter = 0, mode = OFF, period = 1.
- **Accept:** a command is accepted at an edge where `cmd_valid && cmd_ready`.
  - `cmd_mode` is latched, and `cmd_period` is latched as max(`cmd_period`, 1).
  - Next state is APPLY.
- **FSM states:**
  - **IDLE:** `cmd_ready` = 1; `led` holds its value; counters frozen at 0.
  - **APPLY:** lasts exactly one cycle; `cmd_ready` = 0.
    - At the exit edge, prescaler and step counter are cleared, and `led` is loaded: OFF → 000, BLINK → 111, CHASE → 001, COUNT → 000.
    - Next state is IDLE if mode = OFF, otherwise RUN.
  - **RUN:** `cmd_ready` = 1 and `running` = 1.
    - The prescaler counts 0..TICK_DIV-1 and wraps.
    - `tick` (internal) = RUN && prescaler == TICK_DIV-1.
    - On `tick`, the step counter increments. When `tick` && step == period-1, the step counter goes to 0 and `led` advances.
- **Pattern advance:**
  - BLINK: bitwise invert (111↔000).
  - CHASE: rotate left (001→010→100→001).
  - COUNT: `led`+1 modulo 8 (111→000).
- **New command during RUN:** accepted immediately. The current pattern is abandoned, and APPLY reloads the initial pattern and clears both counters. No advance occurs in the accepting cycle, even if `tick` coincides: the command wins.
- **`cmd_valid` during APPLY:** not accepted (`cmd_ready` = 0). It is accepted at the next edge if still asserted.
- **Reset mid-operation:** returns to reset values at that edge and overrides any simultaneous command or tick.
- **Widths:** the step counter is 8 bits. With period 255, steps count 0..254 with no overflow. All counters are unsigned.

## Timing
- Command accepted at edge E0: APPLY during cycle E0→E1. `led` shows the initial pattern and `running` = 1 after E1.
- First advance occurs at edge E1 + TICK_DIV·period. Subsequent advances are every TICK_DIV·period cycles.
- `step_tick` is high exactly in the cycle following each advance edge. It is never asserted for the APPLY load.
- Command-to-`cmd_ready` recovery: `cmd_ready` is low for exactly one cycle per accepted command.

## Test plan
- **Reset:** hold `WB_RST` for 2 edges with `cmd_valid`=1 → `led`=000, `cmd_ready`=1, `running`=0, no accept during reset.
- **CHASE:** TICK_DIV=4, send mode 2, period 2 at E0 → `cmd_ready`=0 for one cycle; `led`=001 after E1, 010 after E9, 100 after E17, 001 after E25; `step_tick` pulses once after each.
- **COUNT wrap:** TICK_DIV=4, mode 3, period 1 → `led` steps 000,001,…,111,000 every 4 cycles; the wrap 111→000 is accompanied by `step_tick`.
- **Period 0 and max:** mode 1, period 0 → toggles every TICK_DIV cycles (as period 1). Period 255 → first toggle 111→000 exactly 255·TICK_DIV cycles after E1.
- **Preempt and OFF:** mid-CHASE, send COUNT on the same edge as a pending advance → no advance, `led`=000 after APPLY. Then send OFF → `led`=000, `running`=0, state IDLE, `led` static for ≥10·TICK_DIV cycles.
- **Reset mid-RUN:** assert `WB_RST` for one edge during COUNT with `led`=101 → all outputs at reset values the next cycle; a fresh command restarts timing from the new E1.
